// File: rtl/fx_pkg.sv
// Shared definitions for the QF fixed-point math blocks: default word
// geometry, saturation limits and the divider state encoding.
package fx_pkg;

    localparam int FX_W = 32;  // total word width, signed two's complement
    localparam int FX_F = 16;  // fractional bits, value = raw / 2^F

    // Largest positive and most negative representable QF words.
    localparam logic [FX_W-1:0] QF_MAX = {1'b0, {(FX_W-1){1'b1}}};
    localparam logic [FX_W-1:0] QF_MIN = {1'b1, {(FX_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } fx_div_st_t;

endpackage

// File: rtl/fx_sat.sv
// Combinational signed saturation: turns an unsigned W+F-bit magnitude plus
// a sign into a W-bit QF word, clamping to QF_MAX / QF_MIN and flagging it.
module fx_sat
    import fx_pkg::*;
(
    input  logic [FX_W+FX_F-1:0] mag,
    input  logic                 neg,
    output logic [FX_W-1:0]      val,
    output logic                 ovf
);

    localparam int W = FX_W;
    localparam int F = FX_F;

    // Magnitude limits zero-extended to the width of the incoming magnitude.
    // A negative result may reach 2^(W-1) in magnitude, a positive one only
    // 2^(W-1)-1.
    localparam logic [W+F-1:0] POS_LIM = {{F{1'b0}}, QF_MAX};
    localparam logic [W+F-1:0] NEG_LIM = {{F{1'b0}}, QF_MIN};

    // Clamp against the signed range, otherwise apply the sign.
    always_comb begin
        val = {W{1'b0}};
        ovf = 1'b0;
        if (!neg && (mag > POS_LIM)) begin
            val = QF_MAX;
            ovf = 1'b1;
        end else if (neg && (mag > NEG_LIM)) begin
            val = QF_MIN;
            ovf = 1'b1;
        end else if (neg) begin
            // mag == 2^(W-1) wraps to QF_MIN, which is the exact answer.
            val = {W{1'b0}} - mag[W-1:0];
            ovf = 1'b0;
        end else begin
            val = mag[W-1:0];
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/fx_div.sv
// Bit-serial signed QF divider (restoring long division, one quotient bit
// per clock). Operands are latched on an accepted start; results are held
// until the next accepted start and flagged by a one-cycle done pulse.
module fx_div
    import fx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_calc,
    input  logic [FX_W-1:0]     num_in,
    input  logic [FX_W-1:0]     den_in,
    output logic                done,
    output logic [FX_W-1:0]     quo_out,
    output logic                invalid,
    output logic                ovf
);

    localparam int W  = FX_W;
    localparam int F  = FX_F;
    localparam int CW = $clog2(W + F);
    localparam logic [CW-1:0] CNT_LAST = CW'(W + F - 1);

    fx_div_st_t      state_q, state_d;
    logic [W-1:0]    num_q, num_d;        // raw numerator as latched
    logic [W-1:0]    den_q, den_d;        // raw denominator as latched
    logic [W+F:0]    dvd_q, dvd_d;        // |num| << F
    logic [W:0]      dvs_q, dvs_d;        // |den|
    logic [W:0]      rem_q, rem_d;        // partial remainder
    logic [W+F-1:0]  quo_q, quo_d;        // unsigned quotient magnitude
    logic [CW-1:0]   cnt_q, cnt_d;        // dividend bit being brought down
    logic            neg_q, neg_d;
    logic            done_q, done_d;
    logic [W-1:0]    quo_out_q, quo_out_d;
    logic            invalid_q, invalid_d;
    logic            ovf_q, ovf_d;

    logic [W:0]      num_abs;
    logic [W:0]      den_abs;
    logic [W+1:0]    r_sh;                // (R << 1) | next dividend bit
    logic [W+1:0]    diff;                // shared subtractor, MSB is the borrow
    logic            ge;
    logic [W-1:0]    sat_val;
    logic            sat_ovf;

    // Magnitudes at W+1 bits so that -2^(W-1) is represented exactly.
    always_comb begin
        if (num_q[W-1]) begin
            num_abs = {(W+1){1'b0}} - {num_q[W-1], num_q};
        end else begin
            num_abs = {1'b0, num_q};
        end
        if (den_q[W-1]) begin
            den_abs = {(W+1){1'b0}} - {den_q[W-1], den_q};
        end else begin
            den_abs = {1'b0, den_q};
        end
    end

    // One restoring-division step: the single trial subtraction decides the
    // quotient bit. rem_q[W] is always zero, so no borrow means R' >= |den|.
    always_comb begin
        r_sh = {rem_q, dvd_q[cnt_q]};
        diff = r_sh - {1'b0, dvs_q};
        ge   = ~diff[W+1];
    end

    fx_sat u_sat (
        .mag (quo_q),
        .neg (neg_q),
        .val (sat_val),
        .ovf (sat_ovf)
    );

    // Next-state and next-register computation for the whole divider.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        den_d     = den_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        quo_out_d = quo_out_q;
        invalid_d = invalid_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start_calc) begin
                    num_d     = num_in;
                    den_d     = den_in;
                    quo_out_d = {W{1'b0}};
                    invalid_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = S_CHECK;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_CHECK: begin
                if (den_q == {W{1'b0}}) begin
                    quo_out_d = {W{1'b0}};
                    invalid_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    neg_d   = num_q[W-1] ^ den_q[W-1];
                    dvd_d   = {num_abs, {F{1'b0}}};
                    dvs_d   = den_abs;
                    rem_d   = {(W+1){1'b0}};
                    quo_d   = {(W+F){1'b0}};
                    cnt_d   = CNT_LAST;
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                if (ge) begin
                    rem_d = diff[W:0];
                end else begin
                    rem_d = r_sh[W:0];
                end
                quo_d = {quo_q[W+F-2:0], ge};
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    state_d = S_ITER;
                end
            end

            S_FIX: begin
                quo_out_d = sat_val;
                ovf_d     = sat_ovf;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any
    // operation in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_q     <= {W{1'b0}};
            den_q     <= {W{1'b0}};
            dvd_q     <= {(W+F+1){1'b0}};
            dvs_q     <= {(W+1){1'b0}};
            rem_q     <= {(W+1){1'b0}};
            quo_q     <= {(W+F){1'b0}};
            cnt_q     <= {CW{1'b0}};
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            quo_out_q <= {W{1'b0}};
            invalid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            den_q     <= den_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            quo_out_q <= quo_out_d;
            invalid_q <= invalid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign done    = done_q;
    assign quo_out = quo_out_q;
    assign invalid = invalid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_fx_div.sv
// Self-checking bench for fx_div: directed cases plus randomized operands,
// each compared against an arithmetic reference model of signed QF division.
module tb_fx_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_calc;
    logic [31:0] num_in;
    logic [31:0] den_in;
    logic        done;
    logic [31:0] quo_out;
    logic        invalid;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fx_div dut (
        .clk        (clk),
        .rst        (rst),
        .start_calc (start_calc),
        .num_in     (num_in),
        .den_in     (den_in),
        .done       (done),
        .quo_out    (quo_out),
        .invalid    (invalid),
        .ovf        (ovf)
    );

    // Single comparison point: counts every check, reports any mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division of |num|*2^16 by |den|, truncated,
    // signed, then clamped to the 32-bit signed range.
    task automatic ref_div(input logic [31:0] n, input logic [31:0] d,
                           output logic [31:0] q, output logic inv, output logic ov);
        longint sn, sd, an, ad, mag, qv;
        logic   neg;
        q   = 32'h0;
        inv = 1'b0;
        ov  = 1'b0;
        if (d == 32'h0) begin
            inv = 1'b1;
        end else begin
            sn  = longint'($signed(n));
            sd  = longint'($signed(d));
            neg = (sn < 0) != (sd < 0);
            an  = (sn < 0) ? -sn : sn;
            ad  = (sd < 0) ? -sd : sd;
            mag = (an * 65536) / ad;
            if (!neg && mag > 64'sd2147483647) begin
                q  = 32'h7FFFFFFF;
                ov = 1'b1;
            end else if (neg && mag > 64'sd2147483648) begin
                q  = 32'h80000000;
                ov = 1'b1;
            end else begin
                qv = neg ? -mag : mag;
                q  = qv[31:0];
            end
        end
    endtask

    // Issue one division and check latency, results, pulse width and hold.
    // inject_cyc > 0 pulses start_calc with junk operands in that cycle.
    task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                          input string tag, input int inject_cyc);
        logic [31:0] eq;
        logic        einv, eov;
        int          done_cyc;
        int          exp_cyc;
        ref_div(n, d, eq, einv, eov);
        exp_cyc = (d == 32'h0) ? 2 : 51;
        @(negedge clk);
        start_calc = 1'b1;
        num_in     = n;
        den_in     = d;
        @(posedge clk);
        #1;
        start_calc = 1'b0;
        num_in     = $urandom;
        den_in     = $urandom;
        done_cyc   = 0;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == inject_cyc) begin
                start_calc = 1'b1;
                num_in     = $urandom;
                den_in     = $urandom;
            end else begin
                start_calc = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start_calc = 1'b0;
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, " quo_out"}, 64'(quo_out), 64'(eq));
        check({tag, " invalid"}, 64'(invalid), 64'(einv));
        check({tag, " ovf"}, 64'(ovf), 64'(eov));
        @(negedge clk);
        check({tag, " done_width"}, 64'(done), 64'd0);
        check({tag, " quo_hold"}, 64'(quo_out), 64'(eq));
    endtask

    initial begin
        logic [31:0] rn, rd;
        int          saw_done;

        rst        = 1'b1;
        start_calc = 1'b1;   // reset must win over a simultaneous start
        num_in     = 32'd65536;
        den_in     = 32'd65536;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset quo_out", 64'(quo_out), 64'd0);
        check("reset invalid", 64'(invalid), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        start_calc = 1'b0;
        rst        = 1'b0;

        // Directed cases from the intended behaviour.
        run_op(32'd196608, 32'd98304, "3.0/1.5", 0);
        check("3.0/1.5 literal", 64'(quo_out), 64'd131072);
        run_op(32'd65536, 32'd196608, "1/3", 0);
        check("1/3 literal", 64'(quo_out), 64'h5555);
        run_op(32'hFFF88000, 32'd131072, "neg_num", 0);
        check("neg_num literal", 64'(quo_out), 64'(32'hFFFC4000));
        run_op(32'd491520, 32'hFFFE0000, "neg_den", 0);
        run_op(32'hFFF88000, 32'hFFFE0000, "both_neg", 0);
        check("both_neg literal", 64'(quo_out), 64'd245760);
        run_op(32'd12345, 32'd0, "div0", 0);
        check("div0 literal", 64'(invalid), 64'd1);
        run_op(32'h7FFFFFFF, 32'd1, "sat_pos", 0);
        run_op(32'h80000000, 32'hFFFF0000, "min_by_m1", 0);
        check("min_by_m1 literal", 64'(ovf), 64'd1);
        run_op(32'h80000000, 32'd65536, "min_by_1", 0);
        check("min_by_1 literal", 64'(quo_out), 64'h80000000);
        run_op(32'h0, 32'hFFFF1234, "zero_num", 0);
        run_op(32'd5, 32'h7FFFFFFF, "tiny", 0);
        run_op(32'd196608, 32'd98304, "ignore_start", 10);
        run_op(32'h80000000, 32'h80000000, "min_by_min", 0);

        // Reset in the middle of an operation: no done, outputs cleared.
        @(negedge clk);
        start_calc = 1'b1;
        num_in     = 32'd196608;
        den_in     = 32'd98304;
        @(posedge clk);
        #1;
        start_calc = 1'b0;
        saw_done   = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            if (c == 20) rst = 1'b1;
            if (c == 21) begin
                rst = 1'b0;
                check("abort quo_out", 64'(quo_out), 64'd0);
                check("abort invalid", 64'(invalid), 64'd0);
                check("abort ovf", 64'(ovf), 64'd0);
            end
        end
        check("abort no_done", 64'(saw_done), 64'd0);
        run_op(32'hFFFF0000, 32'd196608, "after_reset", 0);

        // Randomized operands across several magnitude classes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rn = $urandom;
                    rd = $urandom;
                end
                1: begin
                    rn = $urandom >> $urandom_range(0, 31);
                    rd = $urandom_range(1, 1 << 20);
                end
                2: begin
                    rn = $urandom >> $urandom_range(8, 31);
                    rd = $urandom >> $urandom_range(0, 24);
                end
                default: begin
                    rn = $urandom;
                    rd = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom >> $urandom_range(14, 31));
                end
            endcase
            if ($urandom_range(0, 1) == 1) rn = -rn;
            if ($urandom_range(0, 1) == 1) rd = -rd;
            run_op(rn, rd, $sformatf("rand%0d", i), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fx_div.md
# fx_div

Sequential signed fixed-point divider computing quo = num / den in QF format, one quotient bit per clock (restoring long division). It runs in the opposite direction to the reciprocal unit's Newton iteration: it performs exact bit-serial division of an arbitrary numerator rather than producing an approximate 1/x for a later multiply. It shares the start_calc/done handshake and QF conventions of the fixed-point math blocks in the watchdog datapath.

## Interface
- W, 32, total word width (signed two's complement)
- F, 16, fractional bits (QF, value = raw / 2^F)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start_calc  in  1  request; sampled only in S_IDLE
- num_in  in  W  signed QF numerator; sampled at the start edge only
- den_in  in  W  signed QF denominator; sampled at the start edge only
- done  out  1  one-cycle pulse when the result is valid
- quo_out  out  W  signed QF quotient; registered, held until the next accepted start
- invalid  out  1  den was 0; registered, held like quo_out
- ovf  out  1  result saturated; registered, held like quo_out

## Operation
- States: S_IDLE, S_CHECK, S_ITER, S_FIX, S_DONE.
- S_IDLE:
  - start_calc=1 latches num_in and den_in, clears quo_out, invalid and ovf, then goes to S_CHECK.
  - start_calc is ignored in every other state. No queueing.
- S_CHECK:
  - den=0: quo_out=0, invalid=1, go to S_DONE.
  - Otherwise:
    - neg = num[W-1] ^ den[W-1].
    - Take magnitudes at W+1 bits, so -2^(W-1) is handled exactly.
    - Dividend D = |num| << F, W+F+1 bits. Divisor = |den|.
    - Partial remainder R=0, quotient Q=0, bit counter = W+F-1, go to S_ITER.
- S_ITER, one step per cycle, W+F cycles in total:
  - R' = (R<<1) | D[counter].
  - If R' >= |den|: R = R' - |den| and Q bit set to 1. Otherwise R = R' and Q bit set to 0.
  - Q shifts in MSB-first.
  - Counter reaches 0: go to S_FIX.
- S_FIX:
  - Q is the unsigned magnitude, truncated toward zero. The remainder is discarded.
  - neg=0 and Q > 2^(W-1)-1: quo_out = 2^(W-1)-1, ovf=1.
  - neg=1 and Q > 2^(W-1): quo_out = -2^(W-1), ovf=1.
  - Otherwise quo_out = neg ? -Q : Q.
  - Go to S_DONE.
- S_DONE: done=1 for exactly this cycle, then go to S_IDLE.
- Width rules:
  - R is W+1 bits.
  - The compare/subtract is unsigned at W+1 bits.
  - Q is W+F bits before saturation.
- num=0 with den≠0 follows the normal path and gives quo_out=0, ovf=0.

## Timing
- Reset (rst=1 at a clock edge):
  - State goes to S_IDLE.
  - done=0, quo_out=0, invalid=0, ovf=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- Let start_calc be sampled high at edge 0:
  - S_CHECK during cycle 1.
  - S_ITER during cycles 2 .. W+F+1.
  - S_FIX during cycle W+F+2.
  - done=1 during cycle W+F+3, which is 51 for the defaults.
- Divide-by-zero: done=1 during cycle 2.
- quo_out, invalid and ovf are stable from the done cycle until the edge that accepts the next start.
- Back-to-back: start_calc may be high in the cycle after done. It is accepted, giving a throughput of W+F+4 cycles per operation.
- start_calc held high continuously re-triggers on every return to S_IDLE.
- rst takes priority over start_calc on the same edge.

## Structure
- Package fx_pkg holds:
  - the state enum fx_div_st_t;
  - localparams for QF saturation limits, QF_MAX and QF_MIN, derived from W;
  - the defaults W=32 and F=16, shared with the reciprocal unit.
- One natural sub-module, fx_sat: a combinational signed saturate from a W+F-bit magnitude plus sign to W bits plus an ovf flag, reusable by other QF blocks.
- The iteration datapath stays inline. One shared subtractor is used. No multipliers.

## Test plan
- 3.0/1.5: num=196608, den=98304 -> quo_out=131072 (2.0), done in cycle 51, invalid=0, ovf=0.
- 1/3 truncation: num=65536, den=196608 -> quo_out=21845 (0x5555).
- Sign handling:
  - num=-491520, den=131072 -> quo_out=-245760 (-3.75).
  - The same values with both signs negated -> +245760.
- Divide-by-zero: den=0, num=12345 -> done in cycle 2, quo_out=0, invalid=1, ovf=0.
- Saturation:
  - num=0x7FFFFFFF, den=1 -> quo_out=0x7FFFFFFF, ovf=1.
  - num=0x80000000, den=0xFFFF0000 (-1.0) -> quo_out=0x7FFFFFFF, ovf=1.
  - num=0x80000000, den=65536 -> quo_out=0x80000000, ovf=0.
- Control:
  - start_calc pulsed during S_ITER with different operands -> ignored, and the first result is unchanged.
  - rst asserted at cycle 20 -> no done pulse, all outputs 0.
  - A new start after rst completes normally.
